// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock-enable/divider bank with per-channel tick strobes,
// glitch-free runtime ratio reload and an event counter on channel 0.
module clk_div_bank #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned CNT_W  = 4,
  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              resync,
  input  logic              div_ld,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [DIV_W-1:0]  div_val,
  output logic [NUM_CH-1:0] div_out,
  output logic [NUM_CH-1:0] tick,
  output logic [CNT_W-1:0]  cnt,
  input  logic              cnt_clr
);

  logic [NUM_CH-1:0][DIV_W-1:0] ch_cnt_q, ch_cnt_d;
  logic [NUM_CH-1:0][DIV_W-1:0] ratio_q, ratio_d;
  logic [NUM_CH-1:0][DIV_W-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0]            div_out_q, div_out_d;
  logic [NUM_CH-1:0]            tick_q, tick_d;
  logic [CNT_W-1:0]             ev_cnt_q, ev_cnt_d;

  always_comb begin
    ch_cnt_d  = ch_cnt_q;
    ratio_d   = ratio_q;
    shadow_d  = shadow_q;
    div_out_d = div_out_q;
    tick_d    = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      // An out-of-range div_sel never equals any channel index, so the load is dropped.
      if (div_ld && (div_sel == SEL_W'(i))) begin
        shadow_d[i] = div_val;
      end
      if (resync) begin
        ch_cnt_d[i]  = '0;
        div_out_d[i] = 1'b0;
        ratio_d[i]   = shadow_d[i];
      end else if (ena) begin
        if (ch_cnt_q[i] == ratio_q[i]) begin
          ch_cnt_d[i]  = '0;
          div_out_d[i] = ~div_out_q[i];
          tick_d[i]    = 1'b1;
          // shadow_d already carries a same-cycle load, giving the wrap bypass.
          ratio_d[i]   = shadow_d[i];
        end else begin
          ch_cnt_d[i] = ch_cnt_q[i] + DIV_W'(1);
        end
      end
    end

    ev_cnt_d = ev_cnt_q;
    if (cnt_clr) begin
      ev_cnt_d = '0;
    end else if (div_out_d[0] && !div_out_q[0]) begin
      ev_cnt_d = ev_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        ch_cnt_q[i] <= '0;
        ratio_q[i]  <= DIV_W'((1 << i) - 1);
        shadow_q[i] <= DIV_W'((1 << i) - 1);
      end
      div_out_q <= '0;
      tick_q    <= '0;
      ev_cnt_q  <= '0;
    end else begin
      ch_cnt_q  <= ch_cnt_d;
      ratio_q   <= ratio_d;
      shadow_q  <= shadow_d;
      div_out_q <= div_out_d;
      tick_q    <= tick_d;
      ev_cnt_q  <= ev_cnt_d;
    end
  end

  assign div_out = div_out_q;
  assign tick    = tick_q;
  assign cnt     = ev_cnt_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: reset/default table, hand-written corner
// sequences, and randomized lockstep checking of a 4- and a 3-channel instance.
module tb_clk_div_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena, resync, div_ld, cnt_clr;
  logic [1:0] div_sel;
  logic [7:0] div_val;
  logic [3:0] out_a, tick_a, cnt_a;
  logic [2:0] out_b, tick_b;
  logic [3:0] cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  clk_div_bank dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .resync  (resync),
    .div_ld  (div_ld),
    .div_sel (div_sel),
    .div_val (div_val),
    .div_out (out_a),
    .tick    (tick_a),
    .cnt     (cnt_a),
    .cnt_clr (cnt_clr)
  );

  // Three channels still use a 2-bit select, so div_sel=3 is an out-of-range load.
  clk_div_bank #(.NUM_CH(3)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .resync  (resync),
    .div_ld  (div_ld),
    .div_sel (div_sel),
    .div_val (div_val),
    .div_out (out_b),
    .tick    (tick_b),
    .cnt     (cnt_b),
    .cnt_clr (cnt_clr)
  );

  // Reference model: per instance m, per channel position/ratio/shadow/output.
  int mc[2][4];
  int mr[2][4];
  int ms[2][4];
  bit mo[2][4];
  bit mt[2][4];
  int mcnt[2];
  int nch[2] = '{4, 3};

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int ch = 0; ch < 4; ch++) begin
        mc[m][ch] = 0;
        mr[m][ch] = (1 << ch) - 1;
        ms[m][ch] = (1 << ch) - 1;
        mo[m][ch] = 1'b0;
        mt[m][ch] = 1'b0;
      end
      mcnt[m] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int m = 0; m < 2; m++) begin
      bit old0;
      old0 = mo[m][0];
      for (int ch = 0; ch < nch[m]; ch++) begin
        int nsh;
        nsh = (div_ld && int'(div_sel) == ch) ? int'(div_val) : ms[m][ch];
        mt[m][ch] = 1'b0;
        if (resync) begin
          mc[m][ch] = 0;
          mo[m][ch] = 1'b0;
          mr[m][ch] = nsh;
        end else if (ena) begin
          if (mc[m][ch] == mr[m][ch]) begin
            mc[m][ch] = 0;
            mo[m][ch] = !mo[m][ch];
            mt[m][ch] = 1'b1;
            mr[m][ch] = nsh;
          end else begin
            mc[m][ch]++;
          end
        end
        ms[m][ch] = nsh;
      end
      if (cnt_clr) mcnt[m] = 0;
      else if (!old0 && mo[m][0]) mcnt[m] = (mcnt[m] + 1) % 16;
    end
  endfunction

  function automatic logic [3:0] pk_out(int m);
    logic [3:0] r = '0;
    for (int ch = 0; ch < nch[m]; ch++) r[ch] = mo[m][ch];
    return r;
  endfunction

  function automatic logic [3:0] pk_tick(int m);
    logic [3:0] r = '0;
    for (int ch = 0; ch < nch[m]; ch++) r[ch] = mt[m][ch];
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    ena     = 1'b0;
    resync  = 1'b0;
    div_ld  = 1'b0;
    cnt_clr = 1'b0;
    div_sel = '0;
    div_val = '0;
    model_reset();
    #23;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         ena;
    bit         clr;
    logic [3:0] out;
    logic [3:0] tick;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[18];

  // Edge k after reset: div_out equals k mod 16, tick[i] when 2^i divides k.
  task automatic run_table(input string tag);
    for (int k = 0; k < 18; k++) begin
      ena     = tbl[k].ena;
      cnt_clr = tbl[k].clr;
      step();
      check({tag, "_out"}, out_a, tbl[k].out);
      check({tag, "_tick"}, tick_a, tbl[k].tick);
      check({tag, "_cnt"}, cnt_a, tbl[k].cnt);
    end
    ena     = 1'b1;
    cnt_clr = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 4'h1, 4'b0001, 4'd1};
    tbl[1]  = '{1'b1, 1'b0, 4'h2, 4'b0011, 4'd1};
    tbl[2]  = '{1'b1, 1'b0, 4'h3, 4'b0001, 4'd2};
    tbl[3]  = '{1'b1, 1'b0, 4'h4, 4'b0111, 4'd2};
    tbl[4]  = '{1'b1, 1'b0, 4'h5, 4'b0001, 4'd3};
    tbl[5]  = '{1'b1, 1'b0, 4'h6, 4'b0011, 4'd3};
    tbl[6]  = '{1'b1, 1'b0, 4'h7, 4'b0001, 4'd4};
    tbl[7]  = '{1'b1, 1'b0, 4'h8, 4'b1111, 4'd4};
    tbl[8]  = '{1'b1, 1'b0, 4'h9, 4'b0001, 4'd5};
    tbl[9]  = '{1'b1, 1'b0, 4'ha, 4'b0011, 4'd5};
    tbl[10] = '{1'b1, 1'b0, 4'hb, 4'b0001, 4'd6};
    tbl[11] = '{1'b1, 1'b0, 4'hc, 4'b0111, 4'd6};
    tbl[12] = '{1'b1, 1'b0, 4'hd, 4'b0001, 4'd7};
    tbl[13] = '{1'b1, 1'b0, 4'he, 4'b0011, 4'd7};
    tbl[14] = '{1'b1, 1'b0, 4'hf, 4'b0001, 4'd8};
    tbl[15] = '{1'b1, 1'b0, 4'h0, 4'b1111, 4'd8};
    tbl[16] = '{1'b1, 1'b1, 4'h1, 4'b0001, 4'd0};  // clear wins over a rising edge
    tbl[17] = '{1'b0, 1'b0, 4'h1, 4'b0000, 4'd0};  // frozen: hold, no tick

    // Reset state and default /2,/4,/8,/16 sequence
    do_reset();
    check("rst_out", out_a, 0);
    check("rst_tick", tick_a, 0);
    check("rst_cnt", cnt_a, 0);
    run_table("dflt");

    // Event counter wrap
    do_reset();
    ena = 1'b1;
    repeat (30) step();
    check("wrap_cnt30", cnt_a, 15);
    step();
    check("wrap_cnt31", cnt_a, 0);

    // Mid-period load on ch2: current half-period completes, then every 5 cycles
    do_reset();
    ena = 1'b1;
    step();
    step();
    div_ld  = 1'b1;
    div_sel = 2'd2;
    div_val = 8'd4;
    step();
    div_ld = 1'b0;
    for (int k = 4; k <= 20; k++) begin
      step();
      check("ld2_tick", tick_a[2], (k == 4 || k == 9 || k == 14 || k == 19) ? 1 : 0);
    end

    // ena low for 7 cycles mid-period
    do_reset();
    ena = 1'b1;
    repeat (5) step();
    ena = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      check("frz_out", out_a, 5);
      check("frz_tick", tick_a, 0);
      check("frz_cnt", cnt_a, 3);
    end
    ena = 1'b1;
    step();
    check("res_out", out_a, 6);
    check("res_tick", tick_a, 4'b0011);
    step();
    check("res_cnt", cnt_a, 4);

    // resync with pending shadow ratio 2 on ch1
    do_reset();
    ena = 1'b1;
    step();
    step();
    div_ld  = 1'b1;
    div_sel = 2'd1;
    div_val = 8'd2;
    step();
    div_ld = 1'b0;
    resync = 1'b1;
    step();
    resync = 1'b0;
    check("rsy_out", out_a, 0);
    check("rsy_tick", tick_a, 0);
    check("rsy_cnt", cnt_a, 2);
    step();
    check("rsy1_t1", tick_a[1], 0);
    check("rsy1_cnt", cnt_a, 3);
    step();
    check("rsy2_t1", tick_a[1], 0);
    step();
    check("rsy3_t1", tick_a[1], 1);
    check("rsy3_o1", out_a[1], 1);

    // Asynchronous reset mid-run also restores shadow ratios
    do_reset();
    ena = 1'b1;
    repeat (3) step();
    div_ld  = 1'b1;
    div_sel = 2'd3;
    div_val = 8'd1;
    step();
    div_ld = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_out", out_a, 0);
    check("arst_tick", tick_a, 0);
    check("arst_cnt", cnt_a, 0);
    ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_table("arst");

    // Randomized lockstep against the model, both instances
    do_reset();
    for (int k = 0; k < 800; k++) begin
      ena     = ($urandom_range(0, 9) != 0);
      resync  = ($urandom_range(0, 39) == 0);
      div_ld  = ($urandom_range(0, 4) == 0);
      div_sel = 2'($urandom_range(0, 3));
      div_val = 8'($urandom_range(0, 5));
      cnt_clr = ($urandom_range(0, 49) == 0);
      step();
      check("rnd_a_out", out_a, pk_out(0));
      check("rnd_a_tick", tick_a, pk_tick(0));
      check("rnd_a_cnt", cnt_a, mcnt[0]);
      check("rnd_b_out", {1'b0, out_b}, pk_out(1));
      check("rnd_b_tick", {1'b0, tick_b}, pk_tick(1));
      check("rnd_b_cnt", cnt_b, mcnt[1]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
